cen_accumulator: RTL and testbench
==================================

// Module: cen_accumulator
// PURPOSE
//  Centering-stage front end of the whitening path. Accumulates a block of 2**N_LOG2 signed
//  samples on each of 4 channels. Presents the 4 full-precision block sums to the divide-by-128
//  unit downstream, with a one-cycle strobe that drives that unit's enable.
//  The downstream result (sum>>>7) is the per-channel mean used for centering.
// PARAMETERS
//  DATA_W  14  signed input sample width
//  N_LOG2  7   log2 of block length (128 samples)
//  SUM_W   21  accumulator/output width; must equal DATA_W+N_LOG2 (no overflow possible)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin new block; honoured only in IDLE
//  in_valid   in   1       x1..x4 carry one sample set this cycle
//  x1..x4     in   DATA_W  signed samples, channels 1-4
//  busy       out  1       high in ACCUM and DONE
//  sum_valid  out  1       one-cycle strobe: sum1..4 final (wire to divider En)
//  sum1..sum4 out  SUM_W   signed block sums, held until next start
//  sample_cnt out  N_LOG2  samples accepted in current block (0..127)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, sum_valid=0, sum1..4=0, sample_cnt=0; internal accumulators=0.
//  - FSM: IDLE -> ACCUM on start; ACCUM -> DONE on accepting sample 128; DONE -> IDLE after 1 cycle.
//  - IDLE: in_valid ignored; sums hold the last block. On start: accumulators and sample_cnt
//    cleared next edge. Output sums NOT cleared until the new block completes.
//  - ACCUM: each in_valid cycle, acc_k <= acc_k + sign-extended x_k and sample_cnt += 1.
//    Gaps in in_valid allowed; no timeout. start ignored while busy.
//  - Sample 128 (sample_cnt==127 && in_valid): add it, sum1..4 <= final acc values,
//    and enter DONE on the same edge.
//  - DONE: sum_valid=1 for exactly this cycle; in_valid ignored (sample dropped); sample_cnt wraps to 0.
//  - Latency: sums and sum_valid visible the cycle after the edge that accepts sample 128.
//    Divider result appears one further cycle later.
//  - Arithmetic: two's complement. Sign-extend DATA_W->SUM_W. The range fits exactly:
//    min -2^20, max 2^20-128. No saturation.
//  - start && rst same cycle: rst wins. rst mid-block: abort, sums zeroed, no sum_valid.
//  - start in the DONE cycle: ignored (not queued). Minimum block-to-block gap is 1 IDLE cycle.
// TESTING
//  1 rst, start, 128 cycles in_valid with x1=1, x2=-1, x3=8191, x4=-8192
//    -> one sum_valid pulse; sums 128, -128, 1048448, -1048576.
//  2 same block with in_valid toggling 1/0 (256 cycles)
//    -> identical sums; sum_valid exactly once; sample_cnt steps only on valid cycles.
//  3 ramp x1=i-64 (i=0..127), others 0 -> sum1=-64; sums unchanged until the next block completes.
//  4 rst asserted at sample 60 -> busy=0, sums=0, no sum_valid; a fresh start then completes normally.
//  5 start pulsed mid-ACCUM and in DONE; in_valid in IDLE/DONE
//    -> no restart, no extra accumulation, sums equal to the clean run.
//  6 back-to-back blocks (start in the first IDLE cycle after DONE) with random data
//    -> each sum matches the model; downstream divider output equals sum>>>7.

Source files
------------

// File: rtl/cen_accumulator.sv
// Centering-stage block accumulator: sums 2**N_LOG2 signed samples on four channels
// and strobes the full-precision block sums to the downstream divide-by-block-length unit.
module cen_accumulator #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned N_LOG2 = 7,
    parameter int unsigned SUM_W  = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    input  logic signed [DATA_W-1:0] x4,
    output logic                     busy,
    output logic                     sum_valid,
    output logic signed [SUM_W-1:0]  sum1,
    output logic signed [SUM_W-1:0]  sum2,
    output logic signed [SUM_W-1:0]  sum3,
    output logic signed [SUM_W-1:0]  sum4,
    output logic [N_LOG2-1:0]        sample_cnt
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned EXT_W = SUM_W - DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [N_LOG2-1:0] CNT_LAST = '1;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic                     clear_c;
    logic                     take_c;
    logic                     last_c;

    logic signed [DATA_W-1:0] x_in  [NCH];
    logic signed [SUM_W-1:0]  acc   [NCH];
    logic signed [SUM_W-1:0]  acc_nxt [NCH];
    logic signed [SUM_W-1:0]  sum_q [NCH];

    assign x_in[0] = x1;
    assign x_in[1] = x2;
    assign x_in[2] = x3;
    assign x_in[3] = x4;

    assign sum1 = sum_q[0];
    assign sum2 = sum_q[1];
    assign sum3 = sum_q[2];
    assign sum4 = sum_q[3];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath controls; start is only honoured in IDLE
    always_comb begin
        state_nxt = state;
        clear_c   = 1'b0;
        take_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clear_c   = 1'b1;
                    state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                take_c = in_valid;
                if (in_valid && (sample_cnt == CNT_LAST)) begin
                    last_c    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sign-extended running sums; width is exact so no overflow can occur
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            acc_nxt[k] = acc[k] + {{EXT_W{x_in[k][DATA_W-1]}}, x_in[k]};
        end
    end

    // Registered outputs, accumulators and sample counter
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            sum_valid  <= 1'b0;
            sample_cnt <= '0;
            for (int k = 0; k < NCH; k++) begin
                acc[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            busy      <= (state_nxt != S_IDLE);
            sum_valid <= (state_nxt == S_DONE);
            if (clear_c) begin
                sample_cnt <= '0;
                for (int k = 0; k < NCH; k++) begin
                    acc[k] <= '0;
                end
            end else if (take_c) begin
                sample_cnt <= sample_cnt + N_LOG2'(1);
                for (int k = 0; k < NCH; k++) begin
                    acc[k] <= acc_nxt[k];
                end
            end
            if (last_c) begin
                for (int k = 0; k < NCH; k++) begin
                    sum_q[k] <= acc_nxt[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_cen_accumulator.sv
// Bench for cen_accumulator: table-driven constant blocks, ramp, reset abort,
// ignored start/in_valid, and randomized back-to-back blocks against a plain-sum model.
module tb_cen_accumulator;

    localparam int DATA_W = 14;
    localparam int N_LOG2 = 7;
    localparam int SUM_W  = 21;
    localparam int NS     = 128;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] x1, x2, x3, x4;
    logic                     busy;
    logic                     sum_valid;
    logic signed [SUM_W-1:0]  sum1, sum2, sum3, sum4;
    logic [N_LOG2-1:0]        sample_cnt;

    always #5 clk = ~clk;

    cen_accumulator #(.DATA_W(DATA_W), .N_LOG2(N_LOG2), .SUM_W(SUM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .x1         (x1),
        .x2         (x2),
        .x3         (x3),
        .x4         (x4),
        .busy       (busy),
        .sum_valid  (sum_valid),
        .sum1       (sum1),
        .sum2       (sum2),
        .sum3       (sum3),
        .sum4       (sum4),
        .sample_cnt (sample_cnt)
    );

    // Downstream divide-by-128 unit, enabled by sum_valid
    logic signed [SUM_W-1:0] div_q [4];
    always @(posedge clk) begin
        if (sum_valid) begin
            div_q[0] <= sum1 >>> 7;
            div_q[1] <= sum2 >>> 7;
            div_q[2] <= sum3 >>> 7;
            div_q[3] <= sum4 >>> 7;
        end
    end

    int passed = 0;
    int total  = 0;
    int pulses = 0;

    always @(negedge clk) begin
        if (sum_valid === 1'b1) pulses++;
    end

    int     blk [4][NS];
    longint exp_sum [4];
    longint prev_sum [4];

    typedef struct {
        string  name;
        int     a, b, c, d;
        int     gap;
        longint e1, e2, e3, e4;
    } vec_t;

    vec_t tbl [5];

    function automatic void check(input string name, input longint got, input longint want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endfunction

    function automatic longint floor128(input longint v);
        longint r;
        r = v % 128;
        if (r < 0) r += 128;
        return (v - r) / 128;
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(16383)) - 8192;
    endfunction

    function automatic longint dut_sum(input int k);
        case (k)
            0: return longint'(sum1);
            1: return longint'(sum2);
            2: return longint'(sum3);
            default: return longint'(sum4);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_x();
        x1 = DATA_W'(rnd_sample());
        x2 = DATA_W'(rnd_sample());
        x3 = DATA_W'(rnd_sample());
        x4 = DATA_W'(rnd_sample());
    endtask

    task automatic drive_sample(input int i);
        x1 = DATA_W'(blk[0][i]);
        x2 = DATA_W'(blk[1][i]);
        x3 = DATA_W'(blk[2][i]);
        x4 = DATA_W'(blk[3][i]);
    endtask

    task automatic model_sums();
        for (int k = 0; k < 4; k++) begin
            exp_sum[k] = 0;
            for (int i = 0; i < NS; i++) exp_sum[k] += longint'(blk[k][i]);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NS; i++) blk[k][i] = rnd_sample();
    endtask

    // gap: 0 none, 1 one idle cycle between samples, 2 random idle cycles
    task automatic run_block(input string tag, input int gap, input bit noisy, input bit mid_check);
        int p0;
        p0 = pulses;
        start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
        check($sformatf("%s busy_after_start", tag), longint'(busy), 1);
        for (int i = 0; i < NS; i++) begin
            if (gap != 0 && i > 0 && (gap == 1 || $urandom_range(1) == 1)) begin
                in_valid = 1'b0;
                junk_x();
                if (noisy) start = 1'b1;
                tick();
                start = 1'b0;
                check($sformatf("%s cnt_gap_%0d", tag, i), longint'(sample_cnt), i);
            end
            if (mid_check && i == 64)
                for (int k = 0; k < 4; k++)
                    check($sformatf("%s held_sum%0d", tag, k + 1), dut_sum(k), prev_sum[k]);
            in_valid = 1'b1;
            drive_sample(i);
            if (gap != 0) check($sformatf("%s cnt_%0d", tag, i), longint'(sample_cnt), i);
            tick();
        end
        in_valid = 1'b0;
        if (noisy) begin
            start = 1'b1; in_valid = 1'b1;
            junk_x();
        end
        check($sformatf("%s sum_valid", tag), longint'(sum_valid), 1);
        check($sformatf("%s busy_done", tag), longint'(busy), 1);
        check($sformatf("%s cnt_done", tag), longint'(sample_cnt), 0);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s sum%0d", tag, k + 1), dut_sum(k), exp_sum[k]);
        tick();
        start = 1'b0; in_valid = 1'b0;
        check($sformatf("%s sum_valid_low", tag), longint'(sum_valid), 0);
        check($sformatf("%s busy_idle", tag), longint'(busy), 0);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s mean%0d", tag, k + 1), longint'(div_q[k]), floor128(exp_sum[k]));
        if (noisy) begin
            in_valid = 1'b1;
            junk_x();
            tick();
            tick();
            in_valid = 1'b0;
            check($sformatf("%s busy_idle_noise", tag), longint'(busy), 0);
            check($sformatf("%s cnt_idle_noise", tag), longint'(sample_cnt), 0);
            for (int k = 0; k < 4; k++)
                check($sformatf("%s idle_sum%0d", tag, k + 1), dut_sum(k), exp_sum[k]);
        end
        check($sformatf("%s pulses", tag), longint'(pulses - p0), 1);
        for (int k = 0; k < 4; k++) prev_sum[k] = exp_sum[k];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        x1 = '0; x2 = '0; x3 = '0; x4 = '0;
        for (int k = 0; k < 4; k++) prev_sum[k] = 0;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", longint'(busy), 0);
        check("reset sum_valid", longint'(sum_valid), 0);
        check("reset cnt", longint'(sample_cnt), 0);
        for (int k = 0; k < 4; k++) check($sformatf("reset sum%0d", k + 1), dut_sum(k), 0);

        tbl[0] = '{"const",  1, -1, 8191, -8192, 0, 128, -128, 1048448, -1048576};
        tbl[1] = '{"toggle", 1, -1, 8191, -8192, 1, 128, -128, 1048448, -1048576};
        tbl[2] = '{"max", 8191, 8191, 8191, 8191, 0, 1048448, 1048448, 1048448, 1048448};
        tbl[3] = '{"min", -8192, -8192, -8192, -8192, 2, -1048576, -1048576, -1048576, -1048576};
        tbl[4] = '{"zero", 0, 0, 0, 0, 0, 0, 0, 0, 0};

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < NS; i++) begin
                blk[0][i] = tbl[t].a; blk[1][i] = tbl[t].b;
                blk[2][i] = tbl[t].c; blk[3][i] = tbl[t].d;
            end
            exp_sum[0] = tbl[t].e1; exp_sum[1] = tbl[t].e2;
            exp_sum[2] = tbl[t].e3; exp_sum[3] = tbl[t].e4;
            run_block(tbl[t].name, tbl[t].gap, 1'b0, t > 0);
        end

        // Ramp on channel 1 only, then check it is held through the next block
        for (int i = 0; i < NS; i++) begin
            blk[0][i] = i - 64; blk[1][i] = 0; blk[2][i] = 0; blk[3][i] = 0;
        end
        exp_sum[0] = -64; exp_sum[1] = 0; exp_sum[2] = 0; exp_sum[3] = 0;
        run_block("ramp", 0, 1'b0, 1'b1);
        fill_random();
        model_sums();
        run_block("after_ramp", 2, 1'b0, 1'b1);

        // Reset at sample 60, with start raised in the same cycle
        fill_random();
        p0 = pulses;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'b1;
            drive_sample(i);
            tick();
        end
        check("abort cnt_before_rst", longint'(sample_cnt), 60);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("abort busy", longint'(busy), 0);
        check("abort sum_valid", longint'(sum_valid), 0);
        check("abort cnt", longint'(sample_cnt), 0);
        for (int k = 0; k < 4; k++) check($sformatf("abort sum%0d", k + 1), dut_sum(k), 0);
        tick();
        check("abort start_ignored", longint'(busy), 0);
        check("abort no_pulse", longint'(pulses - p0), 0);
        for (int k = 0; k < 4; k++) prev_sum[k] = 0;
        model_sums();
        run_block("fresh", 0, 1'b0, 1'b1);

        // Ignored start/in_valid, then the same data cleanly
        fill_random();
        model_sums();
        run_block("noisy", 2, 1'b1, 1'b1);
        run_block("clean", 0, 1'b0, 1'b1);

        // Back-to-back random blocks
        for (int b = 0; b < 4; b++) begin
            fill_random();
            model_sums();
            run_block($sformatf("b2b%0d", b), int'($urandom_range(2)), 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
